rob_superscalar: RTL and testbench
==================================

Name: rob_superscalar

Overview:
- Parametrised successor to the single-issue reorder buffer: circular ROB accepting up to ALLOC_WIDTH instructions and retiring up to COMMIT_WIDTH instructions per cycle.
- Snoops NUM_CDB result buses and supports branch-mispredict squash of younger entries.
- Keeps store forwarding by dependence tag and the load-vs-older-store hazard check.
- Sits between dispatch/rename, the CDB arbiter, and architectural-state commit.

Parameters:
- ROB_SIZE, 16, number of entries; power of two, at least 2*max(ALLOC_WIDTH, COMMIT_WIDTH).
- ALLOC_WIDTH, 2, allocation lanes per cycle.
- COMMIT_WIDTH, 2, commit lanes per cycle.
- NUM_CDB, 2, result buses snooped per cycle.
- XLEN, 32, data/address width.
- TAG_W, $clog2(ROB_SIZE), ROB tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- alloc_enable  in  ALLOC_WIDTH  per-lane allocate request; set bits must be contiguous from lane 0
- alloc_wr_mem  in  ALLOC_WIDTH  lane is a store
- alloc_dest_reg  in  ALLOC_WIDTH x 5  destination arch register
- alloc_value_in  in  ALLOC_WIDTH x XLEN  store data, if already known
- alloc_value_in_valid  in  ALLOC_WIDTH  store data valid
- alloc_store_dep  in  ALLOC_WIDTH x TAG_W  ROB tag producing the store data
- alloc_ready  out  1  all requested lanes accepted this cycle
- alloc_slot  out  ALLOC_WIDTH x TAG_W  tag assigned to each lane (tail+i)
- free_count  out  TAG_W+1  free entries, registered
- cdb_valid / cdb_tag / cdb_value  in  NUM_CDB x (1 / TAG_W / XLEN)  result broadcasts
- flush_valid  in  1  mispredict squash
- flush_tag  in  TAG_W  tag of the mispredicted branch; it survives the flush
- read_rob_tag  in  TAG_W  operand read tag
- read_value  out  XLEN  value of that entry
- read_ready  out  1  that entry's value is ready
- load_address  in  XLEN  address to check for store hazards
- load_rob_tag  in  TAG_W  tag of the load being checked
- pending_stores  out  1  an older store conflicts or has an unknown address
- commit_valid  out  COMMIT_WIDTH  lane retires this cycle
- commit_entry  out  COMMIT_WIDTH x ROB_ENTRY  entries retiring, oldest first

Behaviour:
- Reset: head=tail=0, count=0, all entries invalid, free_count=ROB_SIZE, alloc_ready=1, commit_valid=0, pending_stores=0, read_ready=0.
- Entry fields:
  - valid, wr_mem, dest_reg, value, value_ready, dest_addr, addr_ready, store_dep.
  - ready = wr_mem ? (addr_ready & value_ready) : value_ready.
- Allocation:
  - Let k = popcount(alloc_enable).
  - alloc_ready = (free_count + number committing this cycle) >= k. Same-cycle commit frees space, so a full ROB with a ready head still accepts.
  - All or nothing: if alloc_ready=0, no lane is written.
  - Lane i writes entry tail+i mod ROB_SIZE; tail advances by k.
- CDB capture:
  - Non-store entry whose tag matches: value and value_ready set next edge.
  - Store entry whose tag matches: dest_addr and addr_ready set.
  - Store with value_ready=0 whose store_dep matches any cdb_tag: value and value_ready set.
  - Lowest CDB index wins on duplicate tags.
- Allocation-cycle bypass: an allocating store whose alloc_store_dep matches a CDB broadcast in the same cycle captures that value. Otherwise it reads value_ready/value of the producer entry at allocation time.
- Commit:
  - Lane j is valid if entries head..head+j are all valid and ready.
  - At most one store commits per cycle, and only in lane 0; a store in lane j>0 stops the group at j.
  - Head advances by the number committed.
  - commit_entry is combinational from current state; it does not see same-cycle CDB data.
- Flush:
  - Entries strictly younger than flush_tag are invalidated; tail = flush_tag+1; count is recomputed.
  - Same-cycle allocations are dropped; same-cycle commits of entries at or older than flush_tag still occur.
  - CDB writes to squashed tags are ignored.
  - Reset beats flush, and flush beats alloc.
- pending_stores = OR over valid wr_mem entries strictly older than load_rob_tag (age measured relative to head) of (!addr_ready or dest_addr == load_address).
- read_value / read_ready: combinational from the entry at read_rob_tag. No CDB bypass on this port; the reservation station handles that.
- Wrap-around: all tag arithmetic is mod ROB_SIZE. Empty/full is resolved by count, never by head==tail.

Decomposition:
- Shared package holds:
  - ROB_ENTRY struct (fields above).
  - CDB_DATA struct {valid, tag, value}, reused per bus.
  - TAG_W derivation helper.
  - ZERO_REG constant.
- One natural sub-module, rob_commit_select: combinational head-window scan producing commit_valid and the commit count under the single-store rule.

Test Plan:
- Dual alloc dest 3,4 → slots 0,1, free_count 14; CDB0 tag0=5 and CDB1 tag1=7 in the same cycle → next cycle commit_valid=11, values 5/7, free_count 16.
- Fill 16 entries; alloc_ready=1 throughout; a 17th request → alloc_ready=0 and slots unchanged. Make head ready → same-cycle alloc of 1 accepted; tail wraps to 0.
- Two ready adjacent stores at the head → commit_valid=01, then 01 the following cycle.
- Alloc 6 entries (tags 0-5), flush_tag=2 → tail=3, free_count=13; CDB to tag 4 ignored; next alloc gets slot 3.
- Store with alloc_store_dep=tag0 allocated while CDB broadcasts tag0=9 in the same cycle → store value_ready=1, value 9. Address via CDB=0x20 → head ready.
- Older store with address unknown → pending_stores=1 for a younger load. After address 0x20 resolves: load_address 0x24 → 0; load_address 0x20 → 1.

Source files
------------

// File: rtl/rob_superscalar_pkg.sv
// Shared types and constants for the superscalar reorder buffer: entry layout,
// per-bus result record and tag-width helper.
package rob_superscalar_pkg;

    function automatic int tag_width(input int entries);
        return (entries <= 2) ? 1 : $clog2(entries);
    endfunction

    localparam int ROB_SIZE_DEF = 16;
    localparam int XLEN_DEF     = 32;
    localparam int TAG_W_DEF    = tag_width(ROB_SIZE_DEF);

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic                 wr_mem;
        logic [4:0]           dest_reg;
        logic [XLEN_DEF-1:0]  value;
        logic                 value_ready;
        logic [XLEN_DEF-1:0]  dest_addr;
        logic                 addr_ready;
        logic [TAG_W_DEF-1:0] store_dep;
    } rob_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  value;
    } cdb_data_t;

    localparam rob_entry_t EMPTY_ENTRY = '{
        valid: 1'b0, wr_mem: 1'b0, dest_reg: ZERO_REG, value: '0,
        value_ready: 1'b0, dest_addr: '0, addr_ready: 1'b0, store_dep: '0
    };

    // Stores need both address and data; everything else only its result.
    function automatic logic entry_ready(input rob_entry_t e);
        return e.wr_mem ? (e.addr_ready && e.value_ready) : e.value_ready;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Head-window scan: retires an in-order run of ready entries, with a store
// allowed only as the first entry of the group.
module rob_commit_select
    import rob_superscalar_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] head_ok,
    input  logic [COMMIT_WIDTH-1:0] head_store,
    output logic [COMMIT_WIDTH-1:0] commit_valid,
    output logic [CNT_W-1:0]        commit_num
);

    logic run;

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        commit_valid = '0;
        commit_num   = '0;
        run          = 1'b1;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (run && head_ok[j] && (j == 0 || !head_store[j])) begin
                commit_valid[j] = 1'b1;
                commit_num      = commit_num + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_superscalar.sv
// Multi-issue circular reorder buffer: ALLOC_WIDTH allocations and COMMIT_WIDTH
// retirements per cycle, NUM_CDB result snoop, branch squash, store hazard check.
module rob_superscalar
    import rob_superscalar_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int ALLOC_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int NUM_CDB      = 2,
    parameter int XLEN         = XLEN_DEF,
    parameter int TAG_W        = tag_width(ROB_SIZE)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [ALLOC_WIDTH-1:0]              alloc_enable,
    input  logic [ALLOC_WIDTH-1:0]              alloc_wr_mem,
    input  logic [ALLOC_WIDTH-1:0][4:0]         alloc_dest_reg,
    input  logic [ALLOC_WIDTH-1:0][XLEN-1:0]    alloc_value_in,
    input  logic [ALLOC_WIDTH-1:0]              alloc_value_in_valid,
    input  logic [ALLOC_WIDTH-1:0][TAG_W-1:0]   alloc_store_dep,
    output logic                                alloc_ready,
    output logic [ALLOC_WIDTH-1:0][TAG_W-1:0]   alloc_slot,
    output logic [TAG_W:0]                      free_count,
    input  logic [NUM_CDB-1:0]                  cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]       cdb_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]        cdb_value,
    input  logic                                flush_valid,
    input  logic [TAG_W-1:0]                    flush_tag,
    input  logic [TAG_W-1:0]                    read_rob_tag,
    output logic [XLEN-1:0]                     read_value,
    output logic                                read_ready,
    input  logic [XLEN-1:0]                     load_address,
    input  logic [TAG_W-1:0]                    load_rob_tag,
    output logic                                pending_stores,
    output logic [COMMIT_WIDTH-1:0]             commit_valid,
    output rob_entry_t [COMMIT_WIDTH-1:0]       commit_entry
);

    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    rob_entry_t                rob   [ROB_SIZE];
    rob_entry_t                rob_n [ROB_SIZE];
    cdb_data_t [NUM_CDB-1:0]   cdb;
    logic [TAG_W-1:0]          head, tail, head_n, tail_n, flush_age;
    logic [TAG_W:0]            count, count_n, alloc_num, commit_ext;
    logic [CNT_W-1:0]          commit_num;
    logic [COMMIT_WIDTH-1:0]   head_ok, head_store;
    logic                      alloc_fire;

    always_comb begin
        for (int b = 0; b < NUM_CDB; b++) begin
            cdb[b] = '{valid: cdb_valid[b], tag: cdb_tag[b], value: cdb_value[b]};
        end
    end

    assign free_count = (TAG_W+1)'(ROB_SIZE) - count;
    assign flush_age  = flush_tag - head;
    assign commit_ext = (TAG_W+1)'(commit_num);
    assign read_value = rob[read_rob_tag].value;
    assign read_ready = rob[read_rob_tag].valid && rob[read_rob_tag].value_ready;

    // Lanes younger than a same-cycle flush target never retire.
    always_comb begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            commit_entry[j] = rob[head + TAG_W'(j)];
            head_store[j]   = commit_entry[j].wr_mem;
            head_ok[j]      = commit_entry[j].valid && entry_ready(commit_entry[j])
                              && !(flush_valid && TAG_W'(j) > flush_age);
        end
    end

    rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH), .CNT_W(CNT_W)) u_commit_select (
        .head_ok      (head_ok),
        .head_store   (head_store),
        .commit_valid (commit_valid),
        .commit_num   (commit_num)
    );

    always_comb begin
        alloc_num = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_slot[i] = tail + TAG_W'(i);
            if (alloc_enable[i]) alloc_num = alloc_num + (TAG_W+1)'(1);
        end
    end

    assign alloc_ready = (free_count + commit_ext) >= alloc_num;
    assign alloc_fire  = alloc_ready && (alloc_num != '0) && !flush_valid;

    always_comb begin
        pending_stores = 1'b0;
        for (int t = 0; t < ROB_SIZE; t++) begin
            if (rob[t].valid && rob[t].wr_mem
                && (TAG_W'(t) - head) < (load_rob_tag - head)
                && (!rob[t].addr_ready || rob[t].dest_addr == load_address))
                pending_stores = 1'b1;
        end
    end

    // Next-state image: CDB capture, then commit/flush invalidation, then allocation.
    always_comb begin
        rob_entry_t e;
        logic       hit, same_group;
        rob_n = rob;
        e     = EMPTY_ENTRY;
        for (int t = 0; t < ROB_SIZE; t++) begin
            for (int b = NUM_CDB - 1; b >= 0; b--) begin
                if (rob[t].valid && cdb[b].valid) begin
                    if (cdb[b].tag == TAG_W'(t)) begin
                        if (rob[t].wr_mem) begin
                            rob_n[t].dest_addr  = cdb[b].value;
                            rob_n[t].addr_ready = 1'b1;
                        end else begin
                            rob_n[t].value       = cdb[b].value;
                            rob_n[t].value_ready = 1'b1;
                        end
                    end
                    if (rob[t].wr_mem && !rob[t].value_ready && cdb[b].tag == rob[t].store_dep) begin
                        rob_n[t].value       = cdb[b].value;
                        rob_n[t].value_ready = 1'b1;
                    end
                end
            end
            if (flush_valid && (TAG_W'(t) - head) > flush_age) rob_n[t].valid = 1'b0;
        end
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_valid[j]) rob_n[head + TAG_W'(j)].valid = 1'b0;
        end
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            e            = EMPTY_ENTRY;
            e.valid      = 1'b1;
            e.wr_mem     = alloc_wr_mem[i];
            e.dest_reg   = alloc_dest_reg[i];
            e.store_dep  = alloc_store_dep[i];
            hit          = 1'b0;
            same_group   = 1'b0;
            for (int m = 0; m < i; m++) begin
                if (alloc_enable[m] && alloc_slot[m] == alloc_store_dep[i]) same_group = 1'b1;
            end
            if (alloc_wr_mem[i]) begin
                if (alloc_value_in_valid[i]) begin
                    e.value       = alloc_value_in[i];
                    e.value_ready = 1'b1;
                end else begin
                    for (int b = NUM_CDB - 1; b >= 0; b--) begin
                        if (cdb[b].valid && cdb[b].tag == alloc_store_dep[i]) begin
                            e.value       = cdb[b].value;
                            e.value_ready = 1'b1;
                            hit           = 1'b1;
                        end
                    end
                    if (!hit && !same_group) begin
                        e.value       = rob[alloc_store_dep[i]].value;
                        e.value_ready = rob[alloc_store_dep[i]].value_ready;
                    end
                end
            end
            if (alloc_fire && alloc_enable[i]) rob_n[alloc_slot[i]] = e;
        end
    end

    always_comb begin
        head_n = head + TAG_W'(commit_num);
        if (flush_valid) begin
            tail_n  = flush_tag + TAG_W'(1);
            count_n = {1'b0, flush_age} + (TAG_W+1)'(1) - commit_ext;
        end else begin
            tail_n  = tail + (alloc_fire ? TAG_W'(alloc_num) : '0);
            count_n = count - commit_ext + (alloc_fire ? alloc_num : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: entries are reset because their valid/ready bits are control state.
            for (int t = 0; t < ROB_SIZE; t++) rob[t] <= EMPTY_ENTRY;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
            for (int t = 0; t < ROB_SIZE; t++) rob[t] <= rob_n[t];
        end
    end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar: hand-computed expectations for
// allocation, CDB capture, commit grouping, flush and store hazards.
module tb_rob_superscalar;
    import rob_superscalar_pkg::*;

    localparam int ROB_SIZE = 16;
    localparam int AW       = 2;
    localparam int CW       = 2;
    localparam int NC       = 2;
    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [AW-1:0]               alloc_enable, alloc_wr_mem, alloc_value_in_valid;
    logic [AW-1:0][4:0]          alloc_dest_reg;
    logic [AW-1:0][XLEN-1:0]     alloc_value_in;
    logic [AW-1:0][TAG_W-1:0]    alloc_store_dep;
    logic                        alloc_ready;
    logic [AW-1:0][TAG_W-1:0]    alloc_slot;
    logic [TAG_W:0]              free_count;
    logic [NC-1:0]               cdb_valid;
    logic [NC-1:0][TAG_W-1:0]    cdb_tag;
    logic [NC-1:0][XLEN-1:0]     cdb_value;
    logic                        flush_valid;
    logic [TAG_W-1:0]            flush_tag, read_rob_tag, load_rob_tag;
    logic [XLEN-1:0]             read_value, load_address;
    logic                        read_ready, pending_stores;
    logic [CW-1:0]               commit_valid;
    rob_entry_t [CW-1:0]         commit_entry;

    int n_vec = 0;
    int n_bad = 0;

    rob_superscalar #(
        .ROB_SIZE(ROB_SIZE), .ALLOC_WIDTH(AW), .COMMIT_WIDTH(CW),
        .NUM_CDB(NC), .XLEN(XLEN), .TAG_W(TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .alloc_enable(alloc_enable), .alloc_wr_mem(alloc_wr_mem),
        .alloc_dest_reg(alloc_dest_reg), .alloc_value_in(alloc_value_in),
        .alloc_value_in_valid(alloc_value_in_valid), .alloc_store_dep(alloc_store_dep),
        .alloc_ready(alloc_ready), .alloc_slot(alloc_slot), .free_count(free_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .read_rob_tag(read_rob_tag), .read_value(read_value), .read_ready(read_ready),
        .load_address(load_address), .load_rob_tag(load_rob_tag),
        .pending_stores(pending_stores),
        .commit_valid(commit_valid), .commit_entry(commit_entry)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc_enable = '0; alloc_wr_mem = '0; alloc_value_in_valid = '0;
        alloc_dest_reg = '0; alloc_value_in = '0; alloc_store_dep = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        flush_valid = 1'b0; flush_tag = '0;
        read_rob_tag = '0; load_rob_tag = '0; load_address = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic wr, input logic [4:0] dest,
                            input logic [XLEN-1:0] val, input logic vval,
                            input logic [TAG_W-1:0] dep);
        alloc_enable[i]         = 1'b1;
        alloc_wr_mem[i]         = wr;
        alloc_dest_reg[i]       = dest;
        alloc_value_in[i]       = val;
        alloc_value_in_valid[i] = vval;
        alloc_store_dep[i]      = dep;
    endtask

    task automatic cdb_set(input int b, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        cdb_valid[b] = 1'b1;
        cdb_tag[b]   = tag;
        cdb_value[b] = val;
    endtask

    initial begin
        // Reset state and dual allocate / dual CDB / dual commit.
        do_reset();
        settle();
        check("rst_free", 64'(free_count), 16);
        check("rst_alloc_ready", 64'(alloc_ready), 1);
        check("rst_commit_valid", 64'(commit_valid), 0);
        check("rst_pending", 64'(pending_stores), 0);
        check("rst_read_ready", 64'(read_ready), 0);
        set_lane(0, 1'b0, 5'd3, 0, 1'b0, 0);
        set_lane(1, 1'b0, 5'd4, 0, 1'b0, 0);
        settle();
        check("dual_slot0", 64'(alloc_slot[0]), 0);
        check("dual_slot1", 64'(alloc_slot[1]), 1);
        step(); idle(); settle();
        check("dual_free", 64'(free_count), 14);
        cdb_set(0, 4'd0, 32'd5);
        cdb_set(1, 4'd1, 32'd7);
        settle();
        check("commit_no_cdb_bypass", 64'(commit_valid), 0);
        step(); idle(); settle();
        check("dual_commit_valid", 64'(commit_valid), 2'b11);
        check("dual_commit_val0", 64'(commit_entry[0].value), 5);
        check("dual_commit_val1", 64'(commit_entry[1].value), 7);
        check("dual_commit_dest0", 64'(commit_entry[0].dest_reg), 3);
        check("dual_commit_dest1", 64'(commit_entry[1].dest_reg), 4);
        step(); settle();
        check("dual_free_after", 64'(free_count), 16);

        // Fill, reject when full, accept with same-cycle commit, tail wraps.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_lane(0, 1'b0, 5'(2 * c), 0, 1'b0, 0);
            set_lane(1, 1'b0, 5'(2 * c + 1), 0, 1'b0, 0);
            settle();
            check("fill_alloc_ready", 64'(alloc_ready), 1);
            step();
        end
        idle(); settle();
        check("full_free", 64'(free_count), 0);
        set_lane(0, 1'b0, 5'd9, 0, 1'b0, 0);
        settle();
        check("full_alloc_ready", 64'(alloc_ready), 0);
        check("full_slot", 64'(alloc_slot[0]), 0);
        step(); idle(); settle();
        check("full_free_held", 64'(free_count), 0);
        cdb_set(0, 4'd0, 32'd1);
        step(); idle(); settle();
        check("full_head_commit", 64'(commit_valid), 2'b01);
        set_lane(0, 1'b0, 5'd9, 0, 1'b0, 0);
        settle();
        check("full_commit_alloc_ready", 64'(alloc_ready), 1);
        check("full_commit_slot", 64'(alloc_slot[0]), 0);
        step(); idle(); read_rob_tag = 4'd0; settle();
        check("wrap_free", 64'(free_count), 0);
        check("wrap_new_entry_not_ready", 64'(read_ready), 0);
        check("wrap_tail", 64'(alloc_slot[0]), 1);

        // Two adjacent ready stores retire one per cycle.
        do_reset();
        set_lane(0, 1'b1, 5'd0, 32'hA, 1'b1, 0);
        set_lane(1, 1'b1, 5'd0, 32'hB, 1'b1, 0);
        step(); idle();
        cdb_set(0, 4'd0, 32'h100);
        cdb_set(1, 4'd1, 32'h104);
        step(); idle(); settle();
        check("st_commit_first", 64'(commit_valid), 2'b01);
        check("st_first_value", 64'(commit_entry[0].value), 32'hA);
        check("st_first_addr", 64'(commit_entry[0].dest_addr), 32'h100);
        step(); settle();
        check("st_commit_second", 64'(commit_valid), 2'b01);
        check("st_second_value", 64'(commit_entry[0].value), 32'hB);
        check("st_free_mid", 64'(free_count), 15);
        step(); settle();
        check("st_commit_done", 64'(commit_valid), 0);
        check("st_free_end", 64'(free_count), 16);

        // Flush at tag 2 with six live entries.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 1'b0, 5'd1, 0, 1'b0, 0);
            set_lane(1, 1'b0, 5'd2, 0, 1'b0, 0);
            step();
        end
        idle(); settle();
        check("fl_free_before", 64'(free_count), 10);
        flush_valid = 1'b1;
        flush_tag   = 4'd2;
        cdb_set(0, 4'd4, 32'd99);
        set_lane(0, 1'b0, 5'd5, 0, 1'b0, 0);
        step(); idle(); read_rob_tag = 4'd4; settle();
        check("fl_free_after", 64'(free_count), 13);
        check("fl_tail", 64'(alloc_slot[0]), 3);
        check("fl_squashed_cdb_same", 64'(read_ready), 0);
        cdb_set(0, 4'd4, 32'd99);
        step(); idle(); read_rob_tag = 4'd4; settle();
        check("fl_squashed_cdb_later", 64'(read_ready), 0);
        set_lane(0, 1'b0, 5'd6, 0, 1'b0, 0);
        settle();
        check("fl_next_slot", 64'(alloc_slot[0]), 3);
        step(); idle(); settle();
        check("fl_free_realloc", 64'(free_count), 12);

        // Store data captured from the CDB in its allocation cycle.
        do_reset();
        set_lane(0, 1'b0, 5'd1, 0, 1'b0, 0);
        step(); idle();
        set_lane(0, 1'b1, 5'd0, 0, 1'b0, 4'd0);
        cdb_set(0, 4'd0, 32'd9);
        settle();
        check("byp_slot", 64'(alloc_slot[0]), 1);
        step(); idle(); read_rob_tag = 4'd1; settle();
        check("byp_store_ready", 64'(read_ready), 1);
        check("byp_store_value", 64'(read_value), 9);
        check("byp_head_commit", 64'(commit_valid), 2'b01);
        step(); idle(); settle();
        check("byp_store_wait_addr", 64'(commit_valid), 0);
        cdb_set(0, 4'd1, 32'h20);
        step(); idle(); settle();
        check("byp_store_commit", 64'(commit_valid), 2'b01);
        check("byp_store_wr_mem", 64'(commit_entry[0].wr_mem), 1);
        check("byp_store_addr", 64'(commit_entry[0].dest_addr), 32'h20);
        check("byp_store_data", 64'(commit_entry[0].value), 9);

        // Load versus older store hazard.
        do_reset();
        set_lane(0, 1'b1, 5'd0, 32'h55, 1'b1, 0);
        set_lane(1, 1'b0, 5'd7, 0, 1'b0, 0);
        step(); idle();
        load_rob_tag = 4'd1; load_address = 32'h24; settle();
        check("hz_addr_unknown", 64'(pending_stores), 1);
        load_rob_tag = 4'd0; settle();
        check("hz_not_older", 64'(pending_stores), 0);
        cdb_set(0, 4'd0, 32'h20);
        step(); idle();
        load_rob_tag = 4'd1; load_address = 32'h24; settle();
        check("hz_addr_differs", 64'(pending_stores), 0);
        load_address = 32'h20; settle();
        check("hz_addr_matches", 64'(pending_stores), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
